// File: rtl/plot_pkg.sv
// Shared definitions for the plot arbiter: screen size defaults, pixel field
// widths and the controller state type.
package plot_pkg;

   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;
   localparam int X_W          = 8;
   localparam int Y_W          = 7;
   localparam int COLOR_W      = 3;

   typedef enum logic [0:0] {
      S_ARB   = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector.
//   req    : request vector
//   ptr    : index of the previous winner; the search starts at ptr+1 mod NREQ
//   gnt    : one-hot grant (all zero when no request)
//   winner : index of the granted requester (0 when none)
//   any    : at least one request present
module rr_arbiter
   import plot_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   winner,
   output logic            any
);

   function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p, input int i);
      return IW'((int'(p) + 1 + i) % NREQ);
   endfunction

   always_comb begin
      gnt    = '0;
      winner = '0;
      any    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!any && req[rot_idx(ptr, i)]) begin
            any                  = 1'b1;
            gnt[rot_idx(ptr, i)] = 1'b1;
            winner               = rot_idx(ptr, i);
         end
      end
   end

endmodule

// File: rtl/plot_arbiter.sv
// Framebuffer write arbiter: shares one pixel write port between NREQ draw
// requesters (round-robin) and a full-screen clear sweep.
//   clk, reset (async, active low)
//   req/req_x/req_y/req_color : packed per-requester plot requests
//   gnt                        : combinational one-hot grant pulse
//   clear_start/clear_color    : start a full-screen fill
//   clear_busy/clear_done      : sweep in progress / one-cycle completion pulse
//   x/y/color_draw/plot        : registered pixel write to the framebuffer
//   oob                        : granted pixel dropped because it is off-screen
//
// state   | meaning
// S_ARB   | arbitrating draw requests; clear_start wins over req
// S_CLEAR | sweeping every pixel with the latched clear color
module plot_arbiter
   import plot_pkg::*;
#(
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int NREQ     = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*X_W-1:0]     req_x,
   input  logic [NREQ*Y_W-1:0]     req_y,
   input  logic [NREQ*COLOR_W-1:0] req_color,
   output logic [NREQ-1:0]         gnt,
   input  logic                    clear_start,
   input  logic [COLOR_W-1:0]      clear_color,
   output logic                    clear_busy,
   output logic                    clear_done,
   output logic [X_W-1:0]          x,
   output logic [Y_W-1:0]          y,
   output logic [COLOR_W-1:0]      color_draw,
   output logic                    plot,
   output logic                    oob
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t               state, state_nxt;
   logic [IW-1:0]        ptr, ptr_nxt, winner;
   logic [NREQ-1:0]      arb_gnt;
   logic                 arb_any;
   logic [X_W-1:0]       clr_x, clr_x_nxt, x_nxt, win_x;
   logic [Y_W-1:0]       clr_y, clr_y_nxt, y_nxt, win_y;
   logic [COLOR_W-1:0]   color_nxt, win_color;
   logic                 plot_nxt, oob_nxt, busy_nxt, done_nxt;
   logic                 clr_last, win_off;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req    (req),
      .ptr    (ptr),
      .gnt    (arb_gnt),
      .winner (winner),
      .any    (arb_any)
   );

   assign win_x     = req_x[int'(winner)*X_W +: X_W];
   assign win_y     = req_y[int'(winner)*Y_W +: Y_W];
   assign win_color = req_color[int'(winner)*COLOR_W +: COLOR_W];
   assign win_off   = (32'(win_x) >= SCREEN_W) || (32'(win_y) >= SCREEN_H);
   // clr_x/clr_y track the pixel currently presented on x/y during a sweep
   assign clr_last  = (clr_x == X_W'(SCREEN_W - 1)) && (clr_y == Y_W'(SCREEN_H - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_ARB;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_ARB:   if (clear_start) state_nxt = S_CLEAR;
         S_CLEAR: if (clr_last)    state_nxt = S_ARB;
         default: state_nxt = S_ARB;
      endcase
   end

   always_comb begin
      gnt       = '0;
      ptr_nxt   = ptr;
      x_nxt     = x;
      y_nxt     = y;
      color_nxt = color_draw;
      plot_nxt  = 1'b0;
      oob_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      clr_x_nxt = clr_x;
      clr_y_nxt = clr_y;
      case (state)
         S_ARB: begin
            if (clear_start) begin
               // first clear pixel goes out in the very next cycle
               x_nxt     = '0;
               y_nxt     = '0;
               color_nxt = clear_color;
               plot_nxt  = 1'b1;
               busy_nxt  = 1'b1;
               clr_x_nxt = '0;
               clr_y_nxt = '0;
            end else if (arb_any) begin
               // gnt is also qualified by reset so nothing is granted while held in reset
               gnt       = reset ? arb_gnt : '0;
               ptr_nxt   = winner;
               x_nxt     = win_x;
               y_nxt     = win_y;
               color_nxt = win_color;
               plot_nxt  = !win_off;
               oob_nxt   = win_off;
            end
         end
         S_CLEAR: begin
            if (clr_last) begin
               done_nxt  = 1'b1;
               clr_x_nxt = '0;
               clr_y_nxt = '0;
            end else begin
               if (clr_x == X_W'(SCREEN_W - 1)) begin
                  clr_x_nxt = '0;
                  clr_y_nxt = clr_y + 1'b1;
               end else begin
                  clr_x_nxt = clr_x + 1'b1;
               end
               x_nxt    = clr_x_nxt;
               y_nxt    = clr_y_nxt;
               plot_nxt = 1'b1;
               busy_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ptr holds the last winner, so NREQ-1 makes requester 0 the first choice
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr        <= IW'(NREQ - 1);
         x          <= '0;
         y          <= '0;
         color_draw <= '0;
         plot       <= 1'b0;
         oob        <= 1'b0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
         clr_x      <= '0;
         clr_y      <= '0;
      end else begin
         ptr        <= ptr_nxt;
         x          <= x_nxt;
         y          <= y_nxt;
         color_draw <= color_nxt;
         plot       <= plot_nxt;
         oob        <= oob_nxt;
         clear_busy <= busy_nxt;
         clear_done <= done_nxt;
         clr_x      <= clr_x_nxt;
         clr_y      <= clr_y_nxt;
      end
   end

endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, pixel columns swept by clear.
REQ-002 SHALL have parameter SCREEN_H, default 120, pixel rows swept by clear.
REQ-003 SHALL have parameter NREQ, default 3, number of draw requesters.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  NREQ  per-requester plot request, held until granted.
REQ-007 SHALL have port req_x  input  NREQ*8  per-requester x coordinate, requester i in bits [8i+7:8i].
REQ-008 SHALL have port req_y  input  NREQ*7  per-requester y coordinate, packed the same way.
REQ-009 SHALL have port req_color  input  NREQ*3  per-requester color, packed the same way.
REQ-010 SHALL have port gnt  output  NREQ  one-hot, one-cycle grant pulse.
REQ-011 SHALL have port clear_start  input  1  pulse requesting a full-screen clear.
REQ-012 SHALL have port clear_color  input  3  fill color, sampled on accepted clear_start.
REQ-013 SHALL have port clear_busy  output  1  high while a clear sweep is in progress.
REQ-014 SHALL have port clear_done  output  1  one-cycle pulse at clear completion.
REQ-015 SHALL have ports x (output 8), y (output 7), color_draw (output 3): registered pixel to the framebuffer.
REQ-016 SHALL have port plot  output  1  registered write strobe qualifying x/y/color_draw.
REQ-017 SHALL have port oob  output  1  one-cycle pulse when a granted pixel is dropped as off-screen.

Function
REQ-018 SHALL implement FSM states S_ARB and S_CLEAR.
REQ-019 In S_ARB, SHALL grant at most one requester per cycle, round-robin: search starts at (last winner + 1) mod NREQ; pointer reset value selects requester 0 first.
REQ-020 gnt[i] SHALL be combinational in the cycle the winner is chosen; the requester drops or changes req on the following edge.
REQ-021 On grant, SHALL register winner's x/y/color into x/y/color_draw and assert plot in the next cycle (latency 1 from grant edge).
REQ-022 With req held continuously, a single requester SHALL be granted every cycle (throughput 1 pixel/cycle).
REQ-023 Granted pixel with x>=SCREEN_W or y>=SCREEN_H: plot SHALL stay 0, oob SHALL pulse in the plot slot, grant still consumed.
REQ-024 clear_start in S_ARB SHALL take priority over req: no gnt that cycle; clear_color latched; next state S_CLEAR.
REQ-025 In S_CLEAR: plot=1 every cycle, color_draw=latched color; x increments 0..SCREEN_W-1, at wrap x=0 and y increments, rows 0..SCREEN_H-1; total SCREEN_W*SCREEN_H cycles.
REQ-026 In S_CLEAR, gnt SHALL be 0 and pending req left waiting; clear_start SHALL be ignored.
REQ-027 clear_busy SHALL be high from the cycle after accepted clear_start through the last clear pixel's plot cycle.
REQ-028 clear_done SHALL pulse the cycle after the last pixel (SCREEN_W-1, SCREEN_H-1) is plotted; FSM returns to S_ARB that cycle and may grant in it.
REQ-029 Round-robin pointer SHALL be preserved across a clear.
REQ-030 Output coordinate/counter arithmetic SHALL be unsigned, no wrap beyond parameter bounds.

Reset
REQ-031 On reset low, asynchronously: state S_ARB, pointer to requester 0, x=0, y=0, color_draw=0, plot=0, gnt=0, oob=0, clear_busy=0, clear_done=0, clear counters=0.
REQ-032 Reset asserted mid-clear SHALL abort the sweep with no clear_done pulse.
REQ-033 First grant possible in the first clock edge after reset deassertion.

Structure
REQ-034 Package plot_pkg SHALL hold SCREEN_W/SCREEN_H defaults, coordinate and color widths, and the FSM state type.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (req, pointer in; one-hot gnt, winner index out).

Verification
REQ-036 Reset: drive req=3'b111 during reset -> gnt=0, plot=0; after release gnt order 001,010,100,001 on consecutive cycles.
REQ-037 Single requester 1 held, x=10,y=20,color=5 -> gnt[1] every cycle, plot=1 with (10,20,5) one cycle after each grant.
REQ-038 req[0] with x=160,y=5 -> gnt[0] pulse, next cycle plot=0, oob=1.
REQ-039 clear_start with clear_color=2 while req=3'b011 -> no gnt for 19200 cycles, plot with (0,0) first and (159,119) last, clear_done one cycle later, then grant resumes at pointer position.
REQ-040 Reset low at clear pixel (50,30) -> all outputs zero immediately, no clear_done, S_ARB on release.
REQ-041 clear_start re-pulsed mid-clear -> sweep unaffected, exactly one clear_done.
